// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: latches comparator flags, evaluates conditional
// branches against them (with same-cycle compare bypass), issues a one-cycle
// PC load on a taken branch and then holds flush for FLUSH_CYCLES cycles.
module branch_resolve_unit #(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmp_valid,
    input  logic [15:0]       cmp_result,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic              flag_eq,
    output logic              flag_gt,
    output logic              flag_lt,
    output logic              flags_vld,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              cmp_err
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    typedef enum logic [2:0] {
        C_ALWAYS = 3'd0,
        C_EQ     = 3'd1,
        C_NE     = 3'd2,
        C_GT     = 3'd3,
        C_LT     = 3'd4,
        C_GE     = 3'd5,
        C_LE     = 3'd6,
        C_NEVER  = 3'd7
    } cond_t;

    // Counter is loaded with FLUSH_CYCLES-1 so flush spans exactly FLUSH_CYCLES cycles.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] flush_cnt;

    logic cmp_legal;
    logic new_eq, new_gt, new_lt;
    logic eff_eq, eff_gt, eff_lt, eff_vld;
    logic taken;

    // A branch is only offered to the pipeline while no flush is in progress.
    assign br_ready = (state == IDLE);

    // Decode the comparator word and choose bypassed or registered flags for evaluation.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        new_eq    = (cmp_result == 16'h0000);
        new_gt    = (cmp_result == 16'h0001);
        new_lt    = (cmp_result == 16'hFFFF);
        cmp_legal = new_eq | new_gt | new_lt;
        eff_eq    = flag_eq;
        eff_gt    = flag_gt;
        eff_lt    = flag_lt;
        eff_vld   = flags_vld;
        if (cmp_valid && cmp_legal) begin
            eff_eq  = new_eq;
            eff_gt  = new_gt;
            eff_lt  = new_lt;
            eff_vld = 1'b1;
        end
    end

    // Condition evaluation; flag-based conditions are false until a compare has landed.
    always_comb begin
        taken = 1'b0;
        case (cond_t'(br_cond))
            C_ALWAYS: taken = 1'b1;
            C_EQ:     taken = eff_vld & eff_eq;
            C_NE:     taken = eff_vld & ~eff_eq;
            C_GT:     taken = eff_vld & eff_gt;
            C_LT:     taken = eff_vld & eff_lt;
            C_GE:     taken = eff_vld & (eff_gt | eff_eq);
            C_LE:     taken = eff_vld & (eff_lt | eff_eq);
            C_NEVER:  taken = 1'b0;
        endcase
    end

    // Control FSM with registered flags, PC load, flush and error pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
            flag_eq   <= 1'b0;
            flag_gt   <= 1'b0;
            flag_lt   <= 1'b0;
            flags_vld <= 1'b0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            flush     <= 1'b0;
            cmp_err   <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            cmp_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmp_valid) begin
                        if (cmp_legal) begin
                            flag_eq   <= new_eq;
                            flag_gt   <= new_gt;
                            flag_lt   <= new_lt;
                            flags_vld <= 1'b1;
                        end else begin
                            cmp_err <= 1'b1;
                        end
                    end
                    if (br_valid && taken) begin
                        pc_load   <= 1'b1;
                        pc_target <= br_target;
                        flush     <= 1'b1;
                        flush_cnt <= FLUSH_INIT;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Compares and branches arriving here belong to squashed instructions.
                    if (flush_cnt == 4'd0) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run compared against a relation-based behavioural model.
module tb_branch_resolve_unit;

    localparam int ADDR_W       = 16;
    localparam int FLUSH_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmp_valid;
    logic [15:0]       cmp_result;
    logic              br_valid;
    logic [2:0]        br_cond;
    logic [ADDR_W-1:0] br_target;
    logic              br_ready;
    logic              flag_eq, flag_gt, flag_lt, flags_vld;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              flush;
    logic              cmp_err;

    int checks = 0;
    int errors = 0;

    // Model state: compare relation (-1 lt, 0 eq, +1 gt), validity, remaining flush cycles.
    int                m_rel;
    bit                m_vld;
    int                m_flush_left;
    bit                m_pc_load;
    bit                m_cmp_err;
    logic [ADDR_W-1:0] m_pc_target;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .ADDR_W       (ADDR_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmp_valid  (cmp_valid),
        .cmp_result (cmp_result),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .br_target  (br_target),
        .br_ready   (br_ready),
        .flag_eq    (flag_eq),
        .flag_gt    (flag_gt),
        .flag_lt    (flag_lt),
        .flags_vld  (flags_vld),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .flush      (flush),
        .cmp_err    (cmp_err)
    );

    // Status bits: eq gt lt vld pc_load flush cmp_err br_ready
    logic [7:0] st;
    assign st = {flag_eq, flag_gt, flag_lt, flags_vld, pc_load, flush, cmp_err, br_ready};

    function automatic logic [7:0] exp_status();
        return {m_vld && m_rel == 0, m_vld && m_rel > 0, m_vld && m_rel < 0, m_vld,
                m_pc_load, m_flush_left > 0, m_cmp_err, m_flush_left == 0};
    endfunction

    task automatic model_step(input logic rst, input logic cv, input logic [15:0] cr,
                              input logic bv, input logic [2:0] bc, input logic [ADDR_W-1:0] bt);
        int rel;
        bit vld, legal, tk;
        m_pc_load = 0;
        m_cmp_err = 0;
        if (!rst) begin
            m_rel = 0; m_vld = 0; m_flush_left = 0; m_pc_target = '0;
            return;
        end
        if (m_flush_left > 0) begin
            m_flush_left--;
            return;
        end
        legal = (cr == 16'h0000) || (cr == 16'h0001) || (cr == 16'hFFFF);
        rel = m_rel;
        vld = m_vld;
        if (cv && legal) begin
            rel = (cr == 16'h0000) ? 0 : (cr == 16'h0001) ? 1 : -1;
            vld = 1;
        end
        case (bc)
            3'd0: tk = 1;
            3'd1: tk = vld && rel == 0;
            3'd2: tk = vld && rel != 0;
            3'd3: tk = vld && rel > 0;
            3'd4: tk = vld && rel < 0;
            3'd5: tk = vld && rel >= 0;
            3'd6: tk = vld && rel <= 0;
            default: tk = 0;
        endcase
        if (cv) begin
            if (legal) begin m_rel = rel; m_vld = 1; end
            else m_cmp_err = 1;
        end
        if (bv && tk) begin
            m_pc_load    = 1;
            m_pc_target  = bt;
            m_flush_left = FLUSH_CYCLES;
        end
    endtask

    // Apply one cycle of inputs, step the model at the edge, sample 1 ns later.
    task automatic drive(input logic rst, input logic cv, input logic [15:0] cr,
                         input logic bv, input logic [2:0] bc, input logic [ADDR_W-1:0] bt);
        rst_n = rst; cmp_valid = cv; cmp_result = cr;
        br_valid = bv; br_cond = bc; br_target = bt;
        @(posedge clk);
        model_step(rst, cv, cr, bv, bc, bt);
        #1;
        rst_n = 1'b1; cmp_valid = 1'b0; br_valid = 1'b0;
    endtask

    task automatic idle();
        drive(1, 0, 16'h0000, 0, 3'd0, '0);
    endtask

    task automatic test_reset();
        drive(0, 0, 16'h0000, 0, 3'd0, '0);
        checks++;
        if (st !== 8'b0000_0001) begin errors++; $display("FAIL reset_status got %b exp %b", st, 8'b0000_0001); end
        checks++;
        if (pc_target !== 16'h0000) begin errors++; $display("FAIL reset_target got %h exp %h", pc_target, 16'h0000); end
    endtask

    task automatic test_flag_update();
        drive(1, 1, 16'h0001, 0, 3'd0, '0);
        checks++;
        if (st !== 8'b0101_0001) begin errors++; $display("FAIL flag_gt got %b exp %b", st, 8'b0101_0001); end
    endtask

    task automatic test_branch_eq();
        drive(1, 1, 16'h0000, 0, 3'd0, '0);
        checks++;
        if (st !== 8'b1001_0001) begin errors++; $display("FAIL flag_eq got %b exp %b", st, 8'b1001_0001); end
        drive(1, 0, 16'h0000, 1, 3'd1, 16'h0040);
        checks++;
        if (st !== 8'b1001_1100) begin errors++; $display("FAIL beq_load got %b exp %b", st, 8'b1001_1100); end
        checks++;
        if (pc_target !== 16'h0040) begin errors++; $display("FAIL beq_target got %h exp %h", pc_target, 16'h0040); end
        idle();
        checks++;
        if (st !== 8'b1001_0100) begin errors++; $display("FAIL beq_flush2 got %b exp %b", st, 8'b1001_0100); end
        idle();
        checks++;
        if (st !== 8'b1001_0001) begin errors++; $display("FAIL beq_done got %b exp %b", st, 8'b1001_0001); end
    endtask

    task automatic test_bypass();
        drive(1, 1, 16'h0001, 0, 3'd0, '0);
        drive(1, 1, 16'hFFFF, 1, 3'd4, 16'h1234);
        checks++;
        if (st !== 8'b0011_1100) begin errors++; $display("FAIL bypass_lt got %b exp %b", st, 8'b0011_1100); end
        checks++;
        if (pc_target !== 16'h1234) begin errors++; $display("FAIL bypass_target got %h exp %h", pc_target, 16'h1234); end
        idle();
        idle();
        drive(1, 1, 16'h0001, 0, 3'd0, '0);
        drive(1, 1, 16'hFFFF, 1, 3'd3, 16'h5555);
        checks++;
        if (st !== 8'b0011_0001) begin errors++; $display("FAIL bypass_gt_not_taken got %b exp %b", st, 8'b0011_0001); end
        checks++;
        if (pc_target !== 16'h1234) begin errors++; $display("FAIL bypass_target_held got %h exp %h", pc_target, 16'h1234); end
    endtask

    task automatic test_no_flags();
        drive(0, 0, 16'h0000, 0, 3'd0, '0);
        drive(1, 0, 16'h0000, 1, 3'd6, 16'h0777);
        checks++;
        if (st !== 8'b0000_0001) begin errors++; $display("FAIL noflag_le got %b exp %b", st, 8'b0000_0001); end
        drive(1, 0, 16'h0000, 1, 3'd0, 16'h0100);
        checks++;
        if (st !== 8'b0000_1100) begin errors++; $display("FAIL noflag_always got %b exp %b", st, 8'b0000_1100); end
        checks++;
        if (pc_target !== 16'h0100) begin errors++; $display("FAIL noflag_target got %h exp %h", pc_target, 16'h0100); end
        idle();
        idle();
    endtask

    task automatic test_flush_ignore();
        drive(1, 1, 16'h0001, 0, 3'd0, '0);
        drive(1, 0, 16'h0000, 1, 3'd0, 16'h0200);
        drive(1, 1, 16'h0000, 1, 3'd0, 16'h0300);
        checks++;
        if (st !== 8'b0101_0100) begin errors++; $display("FAIL flush_ignore got %b exp %b", st, 8'b0101_0100); end
        checks++;
        if (pc_target !== 16'h0200) begin errors++; $display("FAIL flush_target got %h exp %h", pc_target, 16'h0200); end
        idle();
        checks++;
        if (st !== 8'b0101_0001) begin errors++; $display("FAIL flush_end got %b exp %b", st, 8'b0101_0001); end
        drive(1, 0, 16'h0000, 1, 3'd3, 16'h0400);
        checks++;
        if (st !== 8'b0101_1100) begin errors++; $display("FAIL next_branch got %b exp %b", st, 8'b0101_1100); end
        idle();
        idle();
        drive(1, 1, 16'h0005, 0, 3'd0, '0);
        checks++;
        if (st !== 8'b0101_0011) begin errors++; $display("FAIL illegal_err got %b exp %b", st, 8'b0101_0011); end
        idle();
        checks++;
        if (st !== 8'b0101_0001) begin errors++; $display("FAIL illegal_pulse got %b exp %b", st, 8'b0101_0001); end
    endtask

    task automatic test_reset_mid_flush();
        drive(1, 1, 16'h0000, 0, 3'd0, '0);
        drive(1, 0, 16'h0000, 1, 3'd0, 16'h0600);
        idle();
        checks++;
        if (st !== 8'b1001_0100) begin errors++; $display("FAIL midflush_pre got %b exp %b", st, 8'b1001_0100); end
        drive(0, 0, 16'h0000, 0, 3'd0, '0);
        checks++;
        if (st !== 8'b0000_0001) begin errors++; $display("FAIL midflush_reset got %b exp %b", st, 8'b0000_0001); end
    endtask

    task automatic test_random();
        logic [15:0] cr;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: cr = 16'h0000;
                3, 4, 5: cr = 16'h0001;
                6, 7, 8: cr = 16'hFFFF;
                default: cr = 16'($urandom);
            endcase
            drive(($urandom_range(0, 49) != 0), 1'($urandom), cr, 1'($urandom),
                  3'($urandom), ADDR_W'($urandom));
            checks++;
            if (st !== exp_status()) begin
                errors++;
                $display("FAIL rand_status[%0d] got %b exp %b", i, st, exp_status());
            end
            checks++;
            if (pc_target !== m_pc_target) begin
                errors++;
                $display("FAIL rand_target[%0d] got %h exp %h", i, pc_target, m_pc_target);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cmp_valid = 1'b0; cmp_result = '0;
        br_valid = 1'b0; br_cond = '0; br_target = '0;
        m_rel = 0; m_vld = 0; m_flush_left = 0; m_pc_load = 0; m_cmp_err = 0; m_pc_target = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_flag_update();
        test_branch_eq();
        test_bypass();
        test_no_flags();
        test_flush_ignore();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
